// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALU control codes, the
// supported-code check and the sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Codes 010 and 011 have no ALU function behind them.
  function automatic logic ctrl_supported(input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      ALU_ADD, ALU_SLL, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker, purely combinational.
//  req       in   2  request bits, bit i = port i
//  last      in   1  port granted most recently
//  gnt_valid out  1  at least one request present
//  gnt_idx   out  1  selected port (meaningful only when gnt_valid)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    // On contention the port that did not win last time goes first.
    if (&req) begin
      gnt_idx = ~last;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Sequencer/arbiter letting two requesters share one ALU. One op in flight at a
// time: accept (IDLE) -> drive ALU for one cycle (EXEC) -> hold result (RESP).
//  clk, rst            clock, asynchronous active-high reset
//  req_valid/req_ready per-port request handshake (2 bits, bit i = port i)
//  req_op1/req_op2     per-port operands, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ctrl            per-port 3-bit ALU control, port i at [i*3 +: 3]
//  rsp_valid/rsp_ready per-port response handshake
//  rsp_data/flag/err   registered result, ALU zero flag, unsupported-code flag
//  alu_op1/op2/ctrl    to the shared ALU, non-zero only during EXEC
//  alu_out/alu_zero    from the shared ALU
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [2*DATA_WIDTH-1:0] req_op1,
  input  logic [2*DATA_WIDTH-1:0] req_op2,
  input  logic [5:0]              req_ctrl,
  output logic [1:0]              rsp_valid,
  input  logic [1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_flag,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   alu_op1,
  output logic [DATA_WIDTH-1:0]   alu_op2,
  output logic [2:0]              alu_ctrl,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  input  logic                    alu_zero
);

  state_t                  state_q;
  logic                    last_grant_q;
  logic                    op_port_q;
  logic [DATA_WIDTH-1:0]   op1_q;
  logic [DATA_WIDTH-1:0]   op2_q;
  logic [2:0]              ctrl_q;

  logic                    gnt_valid;
  logic                    gnt_idx;
  logic [DATA_WIDTH-1:0]   sel_op1;
  logic [DATA_WIDTH-1:0]   sel_op2;
  logic [2:0]              sel_ctrl;

  rr_pick2 u_pick (
    .req       (req_valid),
    .last      (last_grant_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_op1  = gnt_idx ? req_op1[2*DATA_WIDTH-1:DATA_WIDTH] : req_op1[DATA_WIDTH-1:0];
    sel_op2  = gnt_idx ? req_op2[2*DATA_WIDTH-1:DATA_WIDTH] : req_op2[DATA_WIDTH-1:0];
    sel_ctrl = gnt_idx ? req_ctrl[5:3] : req_ctrl[2:0];
  end

  // req_ready is combinational from the picker; gated by rst so nothing is
  // offered while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && gnt_valid && !rst) begin
      req_ready = gnt_idx ? 2'b10 : 2'b01;
    end
  end

  // ALU inputs are quiet except in EXEC, and stay quiet for unsupported codes.
  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = 3'b000;
    if (state_q == EXEC && ctrl_supported(ctrl_q)) begin
      alu_op1  = op1_q;
      alu_op2  = op2_q;
      alu_ctrl = ctrl_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_port_q    <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= 3'b000;
      rsp_valid    <= 2'b00;
      rsp_data     <= '0;
      rsp_flag     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            op1_q        <= sel_op1;
            op2_q        <= sel_op2;
            ctrl_q       <= sel_ctrl;
            op_port_q    <= gnt_idx;
            last_grant_q <= gnt_idx;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (ctrl_supported(ctrl_q)) begin
            rsp_data <= alu_out;
            rsp_flag <= alu_zero;
            rsp_err  <= 1'b0;
          end else begin
            rsp_data <= '0;
            rsp_flag <= 1'b0;
            rsp_err  <= 1'b1;
          end
          rsp_valid <= op_port_q ? 2'b10 : 2'b01;
          state_q   <= RESP;
        end
        RESP: begin
          // Only the issuing port's rsp_ready can retire the result.
          if (rsp_ready[op_port_q]) begin
            rsp_valid <= 2'b00;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU behind alu_*.
module tb_alu_share_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*DW-1:0] req_op1;
  logic [2*DW-1:0] req_op2;
  logic [5:0]    req_ctrl;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_flag;
  logic          rsp_err;
  logic [DW-1:0] alu_op1;
  logic [DW-1:0] alu_op2;
  logic [2:0]    alu_ctrl;
  logic [DW-1:0] alu_out;
  logic          alu_zero;

  alu_share_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_flag  (rsp_flag),
    .rsp_err   (rsp_err),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero)
  );

  // Shared ALU
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_out = alu_op1 + alu_op2;
      3'b001:  alu_out = alu_op1 << alu_op2[4:0];
      3'b100:  alu_out = alu_op1 ^ alu_op2;
      3'b101:  alu_out = alu_op1 >> alu_op2[4:0];
      3'b110:  alu_out = alu_op1 | alu_op2;
      3'b111:  alu_out = alu_op1 & alu_op2;
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    logic          flag;
    logic          err;
    int            acc;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic p, input logic [DW-1:0] d, input logic f, input logic e);
    exp_t x;
    x.port = p;
    x.data = d;
    x.flag = f;
    x.err  = e;
    x.acc  = cyc;
    q.push_back(x);
  endtask

  // Present one op on port p until accepted, then check the ALU drive in EXEC.
  task automatic issue(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] c, input logic [DW-1:0] ed, input logic ef,
                       input logic ee);
    bit   got;
    logic sup;
    got = 1'b0;
    req_op1[p*DW +: DW] = a;
    req_op2[p*DW +: DW] = b;
    req_ctrl[p*3 +: 3]  = c;
    req_valid[p]        = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (req_ready[p]) begin
        push(p[0], ed, ef, ee);
        got = 1'b1;
      end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
    if (got) begin
      @(negedge clk);
      sup = (c != 3'b010) && (c != 3'b011);
      chk("exec_alu_op1", alu_op1, sup ? a : 32'd0);
      chk("exec_alu_op2", alu_op2, sup ? b : 32'd0);
      chk("exec_alu_ctrl", alu_ctrl, sup ? c : 3'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid[p]) seen = 1'b1;
    end
    if (!seen) chk("rsp_wait_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    logic          prev_v;
    logic [DW-1:0] prev_d;
    logic          p;
    exp_t          e;
    prev_v = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (rsp_valid != 2'b00) begin
          if (!prev_v) begin
            if (q.size() == 0) chk("unexpected_rsp", rsp_valid, 2'b00);
            else chk("latency", cyc - q[0].acc, 2);
          end else begin
            chk("rsp_hold", rsp_data, prev_d);
          end
          p = rsp_valid[1];
          if (rsp_ready[p] && q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_port", rsp_valid, e.port ? 2'b10 : 2'b01);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_flag", rsp_flag, e.flag);
            chk("rsp_err", rsp_err, e.err);
          end
        end
        prev_v = (rsp_valid != 2'b00);
        prev_d = rsp_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   got;
    logic g;
    logic exp_g;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_op1   = '0;
    req_op2   = '0;
    req_ctrl  = '0;
    rsp_ready = 2'b00;

    #12;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flag", rsp_flag, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 3'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Both ports valid continuously: grants alternate starting with port 0.
    rsp_ready = 2'b11;
    req_op1   = {32'h0000_0001, 32'h0000_F0F0};
    req_op2   = {32'h0000_0004, 32'h0000_0FF0};
    req_ctrl  = {3'b001, 3'b111};
    req_valid = 2'b11;
    exp_g     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (req_ready != 2'b00) got = 1'b1;
      end
      if (!got) begin
        chk("alt_accept_timeout", 64'd0, 64'd1);
      end else begin
        g = req_ready[1];
        chk("grant_order", req_ready, exp_g ? 2'b10 : 2'b01);
        push(g, g ? 32'h10 : 32'hF0, 1'b0, 1'b0);
        exp_g = ~exp_g;
      end
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    drain();

    // Single op: 5 + 7
    issue(0, 32'h5, 32'h7, 3'b000, 32'hC, 1'b0, 1'b0);
    drain();

    // Backpressure on port 1 while port 0 waits
    rsp_ready = 2'b01;
    issue(1, 32'hFF, 32'h0F, 3'b100, 32'hF0, 1'b0, 1'b0);
    req_op1[31:0] = 32'h1;
    req_op2[31:0] = 32'h2;
    req_ctrl[2:0] = 3'b110;
    req_valid[0]  = 1'b1;
    wait_rsp(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_rsp_valid", rsp_valid, 2'b10);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_rsp", req_ready, 2'b01);
    chk("rsp_dropped", rsp_valid, 2'b00);
    push(1'b0, 32'h3, 1'b0, 1'b0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    drain();

    // Unsupported codes, then ops that clear rsp_err
    rsp_ready = 2'b11;
    issue(0, 32'h1234, 32'h5678, 3'b010, 32'h0, 1'b0, 1'b1);
    drain();
    issue(0, 32'h8000_0000, 32'h8000_0000, 3'b000, 32'h0, 1'b1, 1'b0);
    drain();
    issue(1, 32'h7, 32'h7, 3'b011, 32'h0, 1'b0, 1'b1);
    drain();
    issue(1, 32'h100, 32'h4, 3'b101, 32'h10, 1'b0, 1'b0);
    drain();

    // Reset while in RESP: response vanishes and never returns
    rsp_ready = 2'b00;
    issue(0, 32'h9, 32'h3, 3'b000, 32'hC, 1'b0, 1'b0);
    wait_rsp(0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 2'b00);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_req_ready", req_ready, 2'b00);
    q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    rsp_ready = 2'b11;
    repeat (8) @(negedge clk);
    chk("no_rsp_after_rst", rsp_valid, 2'b00);
    @(posedge clk);
    #1;
    issue(0, 32'h8000_0000, 32'h8000_0000, 3'b000, 32'h0, 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
